// File: rtl/rom_reader_pkg.sv
//------------------------------------------------------------------------------
// Module : rom_reader_pkg
// Brief  : Shared FSM encoding, default timing constants and CHIP_LAST_ADDR
//          slice helper for the ROM chip reader.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package rom_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_SETTLE      = 2'd1,
        ST_DUMP_SETTLE = 2'd2,
        ST_DUMP_OUT    = 2'd3
    } scan_state_t;

    localparam int c_DEF_DEBOUNCE_CYCLES = 50000;
    localparam int c_DEF_SETTLE_CYCLES   = 4;
    localparam int c_DEF_REPEAT_DELAY    = 25000000;
    localparam int c_DEF_REPEAT_PERIOD   = 5000000;
    localparam int c_PACK_MAX            = 4096;

    // Chip idx occupies bits [idx*aw +: aw] of the packed last-address vector.
    function automatic logic [31:0] chip_last_slice(
        input logic [c_PACK_MAX-1:0] vec,
        input int                    aw,
        input int                    idx
    );
        return 32'((vec >> (idx * aw)) & ~({c_PACK_MAX{1'b1}} << aw));
    endfunction

endpackage

`default_nettype wire

// File: rtl/button_debouncer.sv
//------------------------------------------------------------------------------
// Module : button_debouncer
// Brief  : 2-FF synchroniser, stability counter and press pulse for an
//          active-low button; optional auto-repeat (ROM_READER_AUTO_REPEAT_EN).
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module button_debouncer
    import rom_reader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = c_DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = c_DEF_REPEAT_PERIOD,
    parameter bit REPEAT_EN       = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_button_n,
    output logic o_press
);

    localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               r_sync0;
    logic               r_sync1;
    logic               r_stable;
    logic               r_press;
    logic [c_CNT_W-1:0] r_cnt;

    if (DEBOUNCE_CYCLES < 1 || (REPEAT_EN && (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1))) begin : g_bad_timing
        $error("button_debouncer: timing parameters must be at least one cycle");
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync0  <= 1'b1;
            r_sync1  <= 1'b1;
            r_stable <= 1'b1;
            r_press  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync0 <= i_button_n;
            r_sync1 <= r_sync0;
            r_press <= 1'b0;
            if (r_sync1 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_stable <= r_sync1;
                r_cnt    <= '0;
                r_press  <= ~r_sync1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

`ifdef ROM_READER_AUTO_REPEAT_EN
    if (REPEAT_EN) begin : g_repeat
        localparam int c_REP_W = $clog2((REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
        localparam logic [c_REP_W-1:0] c_DELAY_LAST  = c_REP_W'(REPEAT_DELAY - 1);
        localparam logic [c_REP_W-1:0] c_PERIOD_LAST = c_REP_W'(REPEAT_PERIOD - 1);

        logic [c_REP_W-1:0] r_rep_cnt;
        logic               r_rep_first;
        logic               r_rep_pulse;

        // Counting starts the cycle the debounced level goes active.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_rep_cnt   <= '0;
                r_rep_first <= 1'b1;
                r_rep_pulse <= 1'b0;
            end else if (r_stable) begin
                r_rep_cnt   <= '0;
                r_rep_first <= 1'b1;
                r_rep_pulse <= 1'b0;
            end else begin
                r_rep_pulse <= 1'b0;
                if (r_rep_cnt == (r_rep_first ? c_DELAY_LAST : c_PERIOD_LAST)) begin
                    r_rep_pulse <= 1'b1;
                    r_rep_first <= 1'b0;
                    r_rep_cnt   <= '0;
                end else begin
                    r_rep_cnt <= r_rep_cnt + 1'b1;
                end
            end
        end

        assign o_press = r_press | r_rep_pulse;
    end else begin : g_no_repeat
        assign o_press = r_press;
    end
`else
    assign o_press = r_press;
`endif

endmodule

`default_nettype wire

// File: rtl/rom_chip_scanner.sv
//------------------------------------------------------------------------------
// Module : rom_chip_scanner
// Brief  : Button-driven chip-select/address sequencer with settle-timed data
//          sampling and valid/ready dump sweep. Option: ROM_READER_AUTO_REPEAT_EN.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module rom_chip_scanner
    import rom_reader_pkg::*;
#(
    parameter int                                ADDR_WIDTH      = 9,
    parameter int                                DATA_WIDTH      = 8,
    parameter int                                CHIP_COUNT      = 2,
    parameter logic [CHIP_COUNT*ADDR_WIDTH-1:0]  CHIP_LAST_ADDR  = {9'd31, 9'd511},
    parameter int                                DEBOUNCE_CYCLES = c_DEF_DEBOUNCE_CYCLES,
    parameter int                                SETTLE_CYCLES   = c_DEF_SETTLE_CYCLES,
    parameter int                                REPEAT_DELAY    = c_DEF_REPEAT_DELAY,
    parameter int                                REPEAT_PERIOD   = c_DEF_REPEAT_PERIOD
) (
    input  logic                  clk,
    input  logic                  reset_button,
    input  logic                  chip_selection_button,
    input  logic                  increment_address_button,
    input  logic                  decrement_address_button,
    input  logic                  dump_button,
    input  logic [DATA_WIDTH-1:0] chip_data_port,
    output logic [ADDR_WIDTH-1:0] chip_address_port,
    output logic [CHIP_COUNT-1:0] chip_enable_n,
    output logic [CHIP_COUNT-1:0] chip_selection_led,
    output logic [DATA_WIDTH-1:0] data_output_port,
    output logic                  dump_valid,
    input  logic                  dump_ready,
    output logic                  dump_active,
    output logic                  dump_done
);

    localparam int                  c_IDX_W     = (CHIP_COUNT > 1) ? $clog2(CHIP_COUNT) : 1;
    localparam logic [c_IDX_W-1:0]  c_IDX_LAST  = c_IDX_W'(CHIP_COUNT - 1);
    localparam logic [CHIP_COUNT-1:0] c_SEL0    = CHIP_COUNT'(1);
    localparam int                  c_SET_W     = $clog2(SETTLE_CYCLES + 1);
    localparam logic [c_SET_W-1:0]  c_SET_LAST  = c_SET_W'(SETTLE_CYCLES - 1);
    // Dump settle runs one cycle longer so a sweep yields a byte every SETTLE_CYCLES+2.
    localparam logic [c_SET_W-1:0]  c_DSET_LAST = c_SET_W'(SETTLE_CYCLES);

    logic w_chip_ev, w_inc_ev, w_dec_ev, w_dump_ev;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
                       .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b0)) u_db_chip (
        .clk(clk), .rst_n(reset_button), .i_button_n(chip_selection_button), .o_press(w_chip_ev));
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
                       .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b1)) u_db_inc (
        .clk(clk), .rst_n(reset_button), .i_button_n(increment_address_button), .o_press(w_inc_ev));
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
                       .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b1)) u_db_dec (
        .clk(clk), .rst_n(reset_button), .i_button_n(decrement_address_button), .o_press(w_dec_ev));
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
                       .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b0)) u_db_dump (
        .clk(clk), .rst_n(reset_button), .i_button_n(dump_button), .o_press(w_dump_ev));

    logic [ADDR_WIDTH-1:0] w_last_tab [CHIP_COUNT];

    for (genvar gi = 0; gi < CHIP_COUNT; gi++) begin : g_last
        assign w_last_tab[gi] = ADDR_WIDTH'(chip_last_slice(c_PACK_MAX'(CHIP_LAST_ADDR), ADDR_WIDTH, gi));
    end

    scan_state_t           r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [c_IDX_W-1:0]    r_idx;
    logic [CHIP_COUNT-1:0] r_en_n;
    logic [CHIP_COUNT-1:0] r_led;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_active;
    logic                  r_done;
    logic [c_SET_W-1:0]    r_cnt;

    logic [ADDR_WIDTH-1:0] w_last;
    logic [c_IDX_W-1:0]    w_idx_next;

    assign w_last     = w_last_tab[r_idx];
    assign w_idx_next = (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;

    always_ff @(posedge clk or negedge reset_button) begin
        if (!reset_button) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_idx    <= '0;
            r_en_n   <= ~c_SEL0;
            r_led    <= c_SEL0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_active <= 1'b0;
            r_done   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_SETTLE: begin
                    if (w_dump_ev) begin
                        r_addr   <= '0;
                        r_active <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= ST_DUMP_SETTLE;
                    end else if (w_chip_ev) begin
                        r_idx   <= w_idx_next;
                        r_addr  <= '0;
                        r_led   <= c_SEL0 << w_idx_next;
                        r_en_n  <= ~(c_SEL0 << w_idx_next);
                        r_cnt   <= '0;
                        r_state <= ST_SETTLE;
                    end else if (w_inc_ev && !w_dec_ev) begin
                        r_addr  <= (r_addr == w_last) ? '0 : r_addr + 1'b1;
                        r_cnt   <= '0;
                        r_state <= ST_SETTLE;
                    end else if (w_dec_ev && !w_inc_ev) begin
                        r_addr  <= (r_addr == '0) ? w_last : r_addr - 1'b1;
                        r_cnt   <= '0;
                        r_state <= ST_SETTLE;
                    end else if (r_state == ST_SETTLE) begin
                        if (r_cnt == c_SET_LAST) begin
                            r_data  <= chip_data_port;
                            r_state <= ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_DUMP_SETTLE: begin
                    if (w_dump_ev) begin
                        r_active <= 1'b0;
                        r_state  <= ST_IDLE;
                    end else if (r_cnt == c_DSET_LAST) begin
                        r_data  <= chip_data_port;
                        r_valid <= 1'b1;
                        r_state <= ST_DUMP_OUT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DUMP_OUT: begin
                    if (w_dump_ev) begin
                        r_valid  <= 1'b0;
                        r_active <= 1'b0;
                        r_state  <= ST_IDLE;
                    end else if (dump_ready) begin
                        r_valid <= 1'b0;
                        if (r_addr == w_last) begin
                            r_active <= 1'b0;
                            r_done   <= 1'b1;
                            r_state  <= ST_IDLE;
                        end else begin
                            r_addr  <= r_addr + 1'b1;
                            r_cnt   <= '0;
                            r_state <= ST_DUMP_SETTLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign chip_address_port  = r_addr;
    assign chip_enable_n      = r_en_n;
    assign chip_selection_led = r_led;
    assign data_output_port   = r_data;
    assign dump_valid         = r_valid;
    assign dump_active        = r_active;
    assign dump_done          = r_done;

endmodule

`default_nettype wire

// File: tb/tb_rom_chip_scanner.sv
//------------------------------------------------------------------------------
// Module : tb_rom_chip_scanner
// Brief  : Self-checking bench for rom_chip_scanner with a small ROM model.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_rom_chip_scanner;

    localparam int DEB = 4;
    localparam int B_CHIP = 0, B_INC = 1, B_DEC = 2, B_DUMP = 3;

    logic       clk = 1'b0;
    logic       reset_button = 1'b0;
    logic       btn_chip = 1'b1, btn_inc = 1'b1, btn_dec = 1'b1, btn_dump = 1'b1;
    logic [7:0] chip_data_port;
    logic [8:0] chip_address_port;
    logic [1:0] chip_enable_n, chip_selection_led;
    logic [7:0] data_output_port;
    logic       dump_valid, dump_ready = 1'b0, dump_active, dump_done;

    int n_checks = 0;
    int n_errors = 0;
    int done_total = 0;
    int m_addr = 0;
    int m_chip = 0;

    rom_chip_scanner #(
        .ADDR_WIDTH(9), .DATA_WIDTH(8), .CHIP_COUNT(2), .CHIP_LAST_ADDR({9'd31, 9'd511}),
        .DEBOUNCE_CYCLES(DEB), .SETTLE_CYCLES(2), .REPEAT_DELAY(20), .REPEAT_PERIOD(5)
    ) dut (
        .clk(clk), .reset_button(reset_button),
        .chip_selection_button(btn_chip), .increment_address_button(btn_inc),
        .decrement_address_button(btn_dec), .dump_button(btn_dump),
        .chip_data_port(chip_data_port), .chip_address_port(chip_address_port),
        .chip_enable_n(chip_enable_n), .chip_selection_led(chip_selection_led),
        .data_output_port(data_output_port), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .dump_active(dump_active), .dump_done(dump_done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom(input int chip, input int addr);
        logic [8:0] a;
        a = addr[8:0];
        return (chip == 1) ? a[7:0] : (a[7:0] ^ 8'h5A);
    endfunction

    function automatic int last_of(input int chip);
        return (chip == 1) ? 31 : 511;
    endfunction

    assign chip_data_port = rom(chip_enable_n[1] ? 0 : 1, int'(chip_address_port));

    always @(negedge clk) if (dump_done) done_total++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            B_CHIP:  btn_chip = v;
            B_INC:   btn_inc  = v;
            B_DEC:   btn_dec  = v;
            default: btn_dump = v;
        endcase
    endtask

    task automatic press(input int b);
        set_btn(b, 1'b0);
        repeat (DEB + 6) tick();
        set_btn(b, 1'b1);
        repeat (DEB + 8) tick();
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_addr"}, int'(chip_address_port), m_addr);
        chk({tag, "_en_n"}, int'(chip_enable_n), 3 ^ (1 << m_chip));
        chk({tag, "_led"},  int'(chip_selection_led), 1 << m_chip);
        chk({tag, "_data"}, int'(data_output_port), int'(rom(m_chip, m_addr)));
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_addr"},   int'(chip_address_port), 0);
        chk({tag, "_en_n"},   int'(chip_enable_n), 2);
        chk({tag, "_led"},    int'(chip_selection_led), 1);
        chk({tag, "_data"},   int'(data_output_port), 0);
        chk({tag, "_valid"},  int'(dump_valid), 0);
        chk({tag, "_active"}, int'(dump_active), 0);
        chk({tag, "_done"},   int'(dump_done), 0);
    endtask

    typedef struct {
        int btn;
        int exp_addr;
        int exp_chip;
    } vec_t;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[13];
        bit   found;
        int   n, d0, b, last, changes;
        logic [8:0] prev;

        tbl[0]  = '{B_INC,  0,   0};
        tbl[1]  = '{B_DEC,  511, 0};
        tbl[2]  = '{B_INC,  0,   0};
        tbl[3]  = '{B_INC,  1,   0};
        tbl[4]  = '{B_CHIP, 0,   1};
        tbl[5]  = '{B_DEC,  31,  1};
        tbl[6]  = '{B_INC,  0,   1};
        tbl[7]  = '{B_DEC,  31,  1};
        tbl[8]  = '{B_CHIP, 0,   0};
        tbl[9]  = '{B_DEC,  511, 0};
        tbl[10] = '{B_INC,  0,   0};
        tbl[11] = '{B_CHIP, 0,   1};
        tbl[12] = '{B_CHIP, 0,   0};

        repeat (3) tick();
        check_reset("init");
        #3 reset_button = 1'b1;
        tick();
        check_reset("post_reset");

        // Decrement from 0 wraps to 511; data follows two cycles after the change.
        btn_dec = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (chip_address_port != 9'd0) begin
                found = 1'b1;
                break;
            end
        end
        chk("settle_seen", int'(found), 1);
        chk("settle_addr", int'(chip_address_port), 511);
        tick();
        chk("settle_data_early", int'(data_output_port), 0);
        tick();
        chk("settle_data", int'(data_output_port), int'(rom(0, 511)));
        btn_dec = 1'b1;
        repeat (DEB + 8) tick();
        m_addr = 511;

        for (int i = 0; i < 13; i++) begin
            press(tbl[i].btn);
            m_addr = tbl[i].exp_addr;
            m_chip = tbl[i].exp_chip;
            check_state($sformatf("tbl%0d", i));
        end

        for (int i = 0; i < 100; i++) press(B_INC);
        m_addr = 100;
        chk("inc100_addr", int'(chip_address_port), 100);
        press(B_CHIP);
        m_chip = 1;
        m_addr = 0;
        check_state("chip_at100");
        press(B_DEC);
        m_addr = 31;
        check_state("chip1_dec");

        btn_inc = 1'b0;
        btn_dec = 1'b0;
        repeat (DEB + 6) tick();
        btn_inc = 1'b1;
        btn_dec = 1'b1;
        repeat (DEB + 8) tick();
        check_state("incdec_same");

        for (int i = 0; i < 40; i++) begin
            b = $urandom_range(0, 9);
            last = last_of(m_chip);
            if (b < 2) begin
                press(B_CHIP);
                m_chip = 1 - m_chip;
                m_addr = 0;
            end else if (b < 6) begin
                press(B_INC);
                m_addr = (m_addr == last) ? 0 : m_addr + 1;
            end else begin
                press(B_DEC);
                m_addr = (m_addr == 0) ? last : m_addr - 1;
            end
            check_state($sformatf("rand%0d", i));
        end
        if (m_chip != 1) begin
            press(B_CHIP);
            m_chip = 1;
            m_addr = 0;
            check_state("to_chip1");
        end

        // Full sweep of chip 1 with ready toggling every cycle.
        d0 = done_total;
        n = 0;
        found = 1'b0;
        btn_dump = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            tick();
            if (i == 10) btn_dump = 1'b1;
            dump_ready = ~dump_ready;
            if (dump_valid && dump_ready) begin
                chk($sformatf("dump_byte%0d", n), int'(data_output_port), int'(rom(1, n)));
                n++;
            end
            if (i > 20 && !dump_active) begin
                found = 1'b1;
                break;
            end
        end
        dump_ready = 1'b0;
        repeat (3) tick();
        chk("dump_finished", int'(found), 1);
        chk("dump_transfers", n, 32);
        chk("dump_done_count", done_total - d0, 1);
        chk("dump_valid_end", int'(dump_valid), 0);
        m_addr = 31;
        check_state("dump_end");

        // Stall at address 10 and abort with a second dump press.
        found = 1'b0;
        btn_dump = 1'b0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (i == 10) btn_dump = 1'b1;
            dump_ready = (chip_address_port != 9'd10);
            if (i > 10 && dump_valid && chip_address_port == 9'd10) begin
                found = 1'b1;
                break;
            end
        end
        chk("abort_reach10", int'(found), 1);
        d0 = done_total;
        press(B_DUMP);
        tick();
        chk("abort_active", int'(dump_active), 0);
        chk("abort_valid", int'(dump_valid), 0);
        chk("abort_no_done", done_total - d0, 0);
        m_addr = 10;
        check_state("abort");
        dump_ready = 1'b0;

        // Asynchronous reset in the middle of a sweep.
        dump_ready = 1'b1;
        press(B_DUMP);
        repeat (5) tick();
        chk("midsweep_active", int'(dump_active), 1);
        #3 reset_button = 1'b0;
        #1 check_reset("async_reset");
        repeat (3) @(posedge clk);
        #1 check_reset("held_reset");
        #3 reset_button = 1'b1;
        dump_ready = 1'b0;
        tick();
        check_reset("after_midsweep");
        m_addr = 0;
        m_chip = 0;

`ifdef ROM_READER_AUTO_REPEAT_EN
        btn_inc = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (chip_address_port != 9'd0) begin
                found = 1'b1;
                break;
            end
        end
        chk("repeat_first", int'(found), 1);
        changes = 1;
        prev = chip_address_port;
        for (int i = 1; i < 40; i++) begin
            tick();
            if (chip_address_port != prev) begin
                changes++;
                prev = chip_address_port;
            end
        end
        chk("repeat_count", changes, 5);
        btn_inc = 1'b1;
        repeat (20) tick();
`else
        changes = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
